// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared 640x480@60 raster timing constants for the VGA path.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int H_ACT  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_ACT  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int H_TOTAL      = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACT + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACT + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Sync level while asserted; 0 selects active-low sync.
  localparam bit SYNC_ACT = 1'b0;

  // Wide enough for totals up to 1024.
  localparam int CNT_W = 10;

endpackage
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter
// Description : Enabled modulo-MAX counter exposing its next value and wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_counter #(
  parameter int MAX = 800,
  parameter int W   = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_count_nxt,
  output logic         o_wrap
);

  localparam logic [W-1:0] C_LAST = W'(MAX - 1);

  logic [W-1:0] r_count;
  logic [W-1:0] w_count_nxt;
  logic         w_last;

  assign w_last = (r_count == C_LAST);

  always_comb begin
    w_count_nxt = r_count;
    if (i_en) begin
      w_count_nxt = w_last ? '0 : r_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  // Wrap flags the terminal count only; the caller qualifies it with its enable.
  assign o_count     = r_count;
  assign o_count_nxt = w_count_nxt;
  assign o_wrap      = w_last;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster counters with aligned HSYNC/VSYNC/BLANK_N strobes
//               and a one-clock frame-start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACT_P    = vga_pkg::H_ACT,
  parameter int H_FP_P     = vga_pkg::H_FP,
  parameter int H_SYNC_P   = vga_pkg::H_SYNC,
  parameter int H_BP_P     = vga_pkg::H_BP,
  parameter int V_ACT_P    = vga_pkg::V_ACT,
  parameter int V_FP_P     = vga_pkg::V_FP,
  parameter int V_SYNC_P   = vga_pkg::V_SYNC,
  parameter int V_BP_P     = vga_pkg::V_BP,
  parameter bit SYNC_ACT_P = vga_pkg::SYNC_ACT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  output logic [CNT_W-1:0] hpixel,
  output logic [CNT_W-1:0] vline,
  output logic             hsync,
  output logic             vsync,
  output logic             blank_n,
  output logic             frame_start
);

  localparam int C_H_TOTAL = H_ACT_P + H_FP_P + H_SYNC_P + H_BP_P;
  localparam int C_V_TOTAL = V_ACT_P + V_FP_P + V_SYNC_P + V_BP_P;

  // One extra bit so a boundary equal to 1024 still compares correctly.
  localparam logic [CNT_W:0] C_H_ACT = (CNT_W+1)'(H_ACT_P);
  localparam logic [CNT_W:0] C_H_SS  = (CNT_W+1)'(H_ACT_P + H_FP_P);
  localparam logic [CNT_W:0] C_H_SE  = (CNT_W+1)'(H_ACT_P + H_FP_P + H_SYNC_P);
  localparam logic [CNT_W:0] C_V_ACT = (CNT_W+1)'(V_ACT_P);
  localparam logic [CNT_W:0] C_V_SS  = (CNT_W+1)'(V_ACT_P + V_FP_P);
  localparam logic [CNT_W:0] C_V_SE  = (CNT_W+1)'(V_ACT_P + V_FP_P + V_SYNC_P);

  logic [CNT_W-1:0] w_h_nxt;
  logic [CNT_W-1:0] w_v_nxt;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_v_en;
  logic [CNT_W:0]   w_h_ext;
  logic [CNT_W:0]   w_v_ext;
  logic             w_h_in_sync;
  logic             w_v_in_sync;
  logic             w_visible;

  logic r_hsync;
  logic r_vsync;
  logic r_blank_n;
  logic r_frame_start;

  assign w_v_en = pix_en & w_h_wrap;

  mod_counter #(.MAX(C_H_TOTAL), .W(CNT_W)) u_hcnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (pix_en),
    .o_count     (hpixel),
    .o_count_nxt (w_h_nxt),
    .o_wrap      (w_h_wrap)
  );

  mod_counter #(.MAX(C_V_TOTAL), .W(CNT_W)) u_vcnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (w_v_en),
    .o_count     (vline),
    .o_count_nxt (w_v_nxt),
    .o_wrap      (w_v_wrap)
  );

  // Decode from next-state counts so registered strobes line up with hpixel/vline.
  assign w_h_ext     = {1'b0, w_h_nxt};
  assign w_v_ext     = {1'b0, w_v_nxt};
  assign w_h_in_sync = (w_h_ext >= C_H_SS) && (w_h_ext < C_H_SE);
  assign w_v_in_sync = (w_v_ext >= C_V_SS) && (w_v_ext < C_V_SE);
  assign w_visible   = (w_h_ext < C_H_ACT) && (w_v_ext < C_V_ACT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync       <= ~SYNC_ACT_P;
      r_vsync       <= ~SYNC_ACT_P;
      r_blank_n     <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= pix_en & w_h_wrap & w_v_wrap;
      if (pix_en) begin
        r_hsync   <= w_h_in_sync ? SYNC_ACT_P : ~SYNC_ACT_P;
        r_vsync   <= w_v_in_sync ? SYNC_ACT_P : ~SYNC_ACT_P;
        r_blank_n <= w_visible;
      end
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign blank_n     = r_blank_n;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench: a default 640x480 instance and a tiny
//               active-high-sync instance driven by shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  // Tiny raster: H 8+2+3+2=15 (sync 10..12), V 4+1+2+2=9 (sync 5..6).
  localparam int BH_ACT = 8, BH_FP = 2, BH_SY = 3, BH_BP = 2;
  localparam int BV_ACT = 4, BV_FP = 1, BV_SY = 2, BV_BP = 2;

  typedef struct { int h; int v; int fs; } st_t;
  typedef struct { int h; int v; int hs; int vs; int bl; int fs; } exp_t;
  typedef struct { exp_t a; exp_t b; } pair_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;

  logic [9:0] a_h, a_v, b_h, b_v;
  logic a_hs, a_vs, a_bl, a_fs, b_hs, b_vs, b_bl, b_fs;

  int total = 0;
  int passed = 0;
  pair_t sbq[$];
  st_t ma, mb;

  int hs_low_a, bl_low_a, vs_act_b, fs_b, bl_hi_b;

  always #5 clk = ~clk;

  vga_timing_gen u_dut_a (
    .clk (clk), .rst_n (rst_n), .pix_en (pix_en),
    .hpixel (a_h), .vline (a_v), .hsync (a_hs), .vsync (a_vs),
    .blank_n (a_bl), .frame_start (a_fs)
  );

  vga_timing_gen #(
    .H_ACT_P (BH_ACT), .H_FP_P (BH_FP), .H_SYNC_P (BH_SY), .H_BP_P (BH_BP),
    .V_ACT_P (BV_ACT), .V_FP_P (BV_FP), .V_SYNC_P (BV_SY), .V_BP_P (BV_BP),
    .SYNC_ACT_P (1'b1)
  ) u_dut_b (
    .clk (clk), .rst_n (rst_n), .pix_en (pix_en),
    .hpixel (b_h), .vline (b_v), .hsync (b_hs), .vsync (b_vs),
    .blank_n (b_bl), .frame_start (b_fs)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic st_t adv(input st_t s, input bit en, input bit rst,
                              input int ht, input int vt);
    st_t n = s;
    if (rst) begin
      n.h = 0; n.v = 0; n.fs = 0;
    end else if (!en) begin
      n.fs = 0;
    end else begin
      n.fs = (s.h == ht-1 && s.v == vt-1) ? 1 : 0;
      if (s.h == ht-1) begin
        n.h = 0;
        n.v = (s.v == vt-1) ? 0 : s.v + 1;
      end else begin
        n.h = s.h + 1;
      end
    end
    return n;
  endfunction

  function automatic exp_t mk(input st_t s, input int ha, input int hss, input int hse,
                              input int va, input int vss, input int vse, input int sa);
    exp_t e;
    e.h  = s.h;
    e.v  = s.v;
    e.hs = (s.h >= hss && s.h < hse) ? sa : 1 - sa;
    e.vs = (s.v >= vss && s.v < vse) ? sa : 1 - sa;
    e.bl = (s.h < ha && s.v < va) ? 1 : 0;
    e.fs = s.fs;
    return e;
  endfunction

  function automatic pair_t cur_exp();
    pair_t p;
    p.a = mk(ma, 640, 656, 752, 480, 490, 492, 0);
    p.b = mk(mb, BH_ACT, BH_ACT+BH_FP, BH_ACT+BH_FP+BH_SY,
             BV_ACT, BV_ACT+BV_FP, BV_ACT+BV_FP+BV_SY, 1);
    return p;
  endfunction

  task automatic cmp(input string dn, input exp_t e, input int h, input int v,
                     input int hs, input int vs, input int bl, input int fs);
    chk({dn, ".hpixel"}, h, e.h);
    chk({dn, ".vline"}, v, e.v);
    chk({dn, ".hsync"}, hs, e.hs);
    chk({dn, ".vsync"}, vs, e.vs);
    chk({dn, ".blank_n"}, bl, e.bl);
    chk({dn, ".frame_start"}, fs, e.fs);
  endtask

  // Monitor: every presented output cycle consumes one scoreboard entry.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      pair_t p;
      p = sbq.pop_front();
      cmp("A", p.a, int'(a_h), int'(a_v), int'(a_hs), int'(a_vs), int'(a_bl), int'(a_fs));
      cmp("B", p.b, int'(b_h), int'(b_v), int'(b_hs), int'(b_vs), int'(b_bl), int'(b_fs));
    end
  end

  task automatic clr();
    hs_low_a = 0; bl_low_a = 0; vs_act_b = 0; fs_b = 0; bl_hi_b = 0;
  endtask

  task automatic tally();
    if (a_hs == 1'b0) hs_low_a++;
    if (a_bl == 1'b0) bl_low_a++;
    if (b_vs == 1'b1) vs_act_b++;
    if (b_fs == 1'b1) fs_b++;
    if (b_bl == 1'b1) bl_hi_b++;
  endtask

  task automatic cycle(input bit en);
    @(negedge clk);
    pix_en = en;
    @(posedge clk);
    ma = adv(ma, en, !rst_n, 800, 525);
    mb = adv(mb, en, !rst_n, BH_ACT+BH_FP+BH_SY+BH_BP, BV_ACT+BV_FP+BV_SY+BV_BP);
    sbq.push_back(cur_exp());
    #1 tally();
  endtask

  initial begin
    ma = '{0, 0, 0};
    mb = '{0, 0, 0};
    clr();
    repeat (3) cycle(1'b0);
    #1 rst_n = 1'b1;

    // One full line of the default raster.
    clr();
    tally();
    repeat (799) cycle(1'b1);
    chk("line.hsync_low_cycles", hs_low_a, 96);
    chk("line.blank_low_cycles", bl_low_a, 160);
    cycle(1'b1);
    chk("line.wrap_h", int'(a_h), 0);
    chk("line.wrap_v", int'(a_v), 1);

    // Freeze inside the horizontal sync pulse.
    repeat (700) cycle(1'b1);
    chk("freeze.at_h", int'(a_h), 700);
    chk("freeze.hsync_active", int'(a_hs), 0);
    repeat (50) cycle(1'b0);
    chk("freeze.held_h", int'(a_h), 700);
    chk("freeze.held_hsync", int'(a_hs), 0);
    cycle(1'b1);
    chk("freeze.resume_h", int'(a_h), 701);

    // Asynchronous reset mid-cycle.
    repeat (599) cycle(1'b1);
    chk("areset.pre_h", int'(a_h), 500);
    chk("areset.pre_v", int'(a_v), 2);
    #1 rst_n = 1'b0;
    #1;
    ma = '{0, 0, 0};
    mb = '{0, 0, 0};
    sbq[sbq.size()-1] = cur_exp();
    chk("areset.now_h", int'(a_h), 0);
    chk("areset.now_blank_n", int'(a_bl), 1);
    chk("areset.now_b_hsync", int'(b_hs), 0);
    repeat (2) cycle(1'b1);
    #1 rst_n = 1'b1;
    cycle(1'b1);
    chk("areset.restart_h", int'(a_h), 1);
    chk("areset.restart_fs", int'(a_fs), 0);

    // Full tiny frame with continuous enable.
    clr();
    repeat (135) cycle(1'b1);
    chk("frameB.vsync_cycles", vs_act_b, 30);
    chk("frameB.fs_pulses", fs_b, 1);
    chk("frameB.visible_cycles", bl_hi_b, 32);

    // Half-rate enable: two tiny frames in 540 clocks.
    clr();
    repeat (270) begin
      cycle(1'b1);
      cycle(1'b0);
    end
    chk("halfrate.fs_cycles", fs_b, 2);
    chk("halfrate.vsync_cycles", vs_act_b, 120);

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    chk("scoreboard.drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: timeout, got %0d passed expected run completion", passed);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
